// File: rtl/sdram_pkg.sv
// sdram_pkg: command encodings, mode-register fields, burst/CL decode and error bit indices
package sdram_pkg;
  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;
  typedef enum logic [1:0] {S_WAIT_PALL, S_WAIT_REF, S_WAIT_MRS, S_RUN} init_e;
  localparam int MRS_CL_LSB = 4;
  localparam int MRS_BL_LSB = 0;
  localparam int ADR_ALL = 10;
  localparam int COL_BITS = 9;
  localparam logic [2:0] CL_DEFAULT = 3'd3;
  localparam logic [2:0] BL_1 = 3'b000;
  localparam logic [2:0] BL_2 = 3'b001;
  localparam logic [2:0] BL_4 = 3'b010;
  localparam logic [2:0] BL_8 = 3'b011;
  localparam logic [2:0] BL_PAGE = 3'b111;
  localparam int ERR_INIT = 0;
  localparam int ERR_IDLE = 1;
  localparam int ERR_OPEN = 2;
  localparam int ERR_BUSY = 3;
  localparam int ERR_CL = 4;
  // column bits that advance inside a burst; unknown codes behave as a single beat
  function automatic logic [COL_BITS-1:0] bl_mask(input logic [2:0] bl, input int col_sel);
    return bl == BL_2 ? 9'd1 : bl == BL_4 ? 9'd3 : bl == BL_8 ? 9'd7 :
           bl == BL_PAGE ? COL_BITS'((1 << col_sel) - 1) : 9'd0;
  endfunction
  function automatic logic cl_ok(input logic [2:0] cl);
    return cl == 3'd2 || cl == 3'd3;
  endfunction
endpackage

// File: rtl/sdram_resp_bank.sv
// sdram_resp_bank: open/idle state, open row and busy timer of one bank
module sdram_resp_bank #(
  parameter int ROW_ADRESS = 13,
  parameter int TRCD       = 3,
  parameter int TRP        = 3,
  parameter int TRC        = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_act,
  input  logic                  i_pre,
  input  logic                  i_ref,
  input  logic [ROW_ADRESS-1:0] i_row,
  output logic                  o_open,
  output logic                  o_busy,
  output logic [ROW_ADRESS-1:0] o_row
);
  localparam int TMAX = TRC > TRCD ? (TRC > TRP ? TRC : TRP) : (TRCD > TRP ? TRCD : TRP);
  localparam int CW = $clog2(TMAX + 1);
  logic r_open;
  logic [ROW_ADRESS-1:0] r_row;
  logic [CW-1:0] r_cnt;
  // activate only opens an idle bank; every command reloads the busy timer
  always_ff @(posedge clk)
    if (rst) begin
      r_open <= 1'b0;
      r_row <= '0;
      r_cnt <= '0;
    end else if (i_act && !r_open) begin
      r_open <= 1'b1;
      r_row <= i_row;
      r_cnt <= CW'(TRCD);
    end else if (i_pre) begin
      r_open <= 1'b0;
      r_cnt <= CW'(TRP);
    end else if (i_ref) r_cnt <= CW'(TRC);
    else if (|r_cnt) r_cnt <= r_cnt - 1'b1;
  assign o_open = r_open;
  assign o_busy = |r_cnt;
  assign o_row = r_row;
endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: SDRAM device model with init checking, per-bank timing and burst data
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int BANK_NUM     = 4,
  parameter int ROW_ADRESS   = 13,
  parameter int COLUMN_WIDTH = 16,
  parameter int ROW_SEL      = 2,
  parameter int COL_SEL      = 4,
  parameter int TRCD         = 3,
  parameter int TRP          = 3,
  parameter int TRC          = 9
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CKE,
  input  logic                        CS,
  input  logic                        RAS,
  input  logic                        CAS,
  input  logic                        WE,
  input  logic [ROW_ADRESS-1:0]       ADR,
  input  logic [$clog2(BANK_NUM)-1:0] BDR,
  input  logic [COLUMN_WIDTH-1:0]     DQ_IN,
  output logic [COLUMN_WIDTH-1:0]     DQ_OUT,
  output logic                        DQ_OE,
  output logic                        READY,
  output logic [2:0]                  CAS_LAT,
  output logic [4:0]                  ERR
);
  localparam int BW = $clog2(BANK_NUM);
  localparam int AW = BW + ROW_SEL + COL_SEL;
  cmd_e w_cmd;
  init_e r_state, w_state_nxt;
  logic w_run, w_await, w_err_init, w_mrs, w_act, w_pre, w_ref, w_rw, w_bst, w_acc, w_kill, w_beat, w_bwr;
  logic [BANK_NUM-1:0] w_open, w_busy;
  logic [BANK_NUM-1:0][ROW_ADRESS-1:0] w_row;
  logic [4:0] w_err_set, r_err;
  logic [2:0] r_cl, r_bl;
  logic r_bst_act, r_bst_wr, r_bst_full;
  logic [BW-1:0] r_bst_bank, w_bbank;
  logic [ROW_SEL-1:0] r_bst_row, w_brow;
  logic [COL_BITS-1:0] r_bst_col, r_bst_left, r_bst_mask, w_bcol, w_bmask, w_bcol_nxt;
  logic [AW-1:0] w_idx;
  logic [COLUMN_WIDTH-1:0] r_mem [1 << AW];
  logic [2:0] r_pv;
  logic [COLUMN_WIDTH-1:0] r_pd [3];
  logic w_unused;
  assign w_cmd = (CKE && !CS) ? cmd_e'({RAS, CAS, WE}) : CMD_NOP;
  assign w_run = r_state == S_RUN;
  assign w_mrs = w_cmd == CMD_MRS && (w_run || w_await);
  assign w_act = w_run && w_cmd == CMD_ACT;
  assign w_pre = w_run && w_cmd == CMD_PRE;
  assign w_ref = w_run && w_cmd == CMD_REF;
  assign w_bst = w_run && w_cmd == CMD_BST;
  assign w_rw = w_run && (w_cmd == CMD_RD || w_cmd == CMD_WR);
  assign w_acc = w_rw && w_open[BDR];
  assign w_unused = ^w_row;
  // init sequencing: advance on the awaited command, flag any other command
  always_comb begin
    w_await = r_state == S_WAIT_PALL ? (w_cmd == CMD_PRE && ADR[ADR_ALL]) :
              r_state == S_WAIT_REF ? w_cmd == CMD_REF : w_cmd == CMD_MRS;
    w_state_nxt = (w_run || !w_await) ? r_state :
                  r_state == S_WAIT_PALL ? S_WAIT_REF : r_state == S_WAIT_REF ? S_WAIT_MRS : S_RUN;
    w_err_init = !w_run && !w_await && w_cmd != CMD_NOP;
  end
  // protocol violations detected this cycle
  always_comb begin
    w_err_set = '0;
    w_err_set[ERR_INIT] = w_err_init;
    w_err_set[ERR_IDLE] = (w_rw && !w_open[BDR]) || (w_ref && |w_open);
    w_err_set[ERR_OPEN] = w_act && w_open[BDR];
    w_err_set[ERR_BUSY] = (w_act || w_acc) && w_busy[BDR];
    w_err_set[ERR_CL] = w_mrs && !cl_ok(ADR[MRS_CL_LSB +: 3]);
  end
  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    sdram_resp_bank #(.ROW_ADRESS(ROW_ADRESS), .TRCD(TRCD), .TRP(TRP), .TRC(TRC)) u_bank (
      .clk(CLK), .rst(RST),
      .i_act(w_act && BDR == BW'(b)),
      .i_pre(w_pre && (ADR[ADR_ALL] || BDR == BW'(b))),
      .i_ref(w_ref && !(|w_open)),
      .i_row(ADR),
      .o_open(w_open[b]), .o_busy(w_busy[b]), .o_row(w_row[b])
    );
  end
  // current beat: a new access takes the port, otherwise the running burst continues
  always_comb begin
    w_kill = w_acc || w_bst || (w_pre && (ADR[ADR_ALL] || BDR == r_bst_bank));
    w_beat = w_acc || (r_bst_act && !w_kill);
    w_bwr = w_acc ? w_cmd == CMD_WR : r_bst_wr;
    w_bbank = w_acc ? BDR : r_bst_bank;
    w_brow = w_acc ? w_row[BDR][ROW_SEL-1:0] : r_bst_row;
    w_bcol = w_acc ? ADR[COL_BITS-1:0] : r_bst_col;
    w_bmask = w_acc ? bl_mask(r_bl, COL_SEL) : r_bst_mask;
    w_bcol_nxt = (w_bcol & ~w_bmask) | ((w_bcol + 1'b1) & w_bmask);
    w_idx = {w_bbank, w_brow, w_bcol[COL_SEL-1:0]};
  end
  // init state, sticky errors and mode register
  always_ff @(posedge CLK)
    if (RST) begin
      r_state <= S_WAIT_PALL;
      r_err <= '0;
      r_cl <= CL_DEFAULT;
      r_bl <= BL_1;
    end else begin
      r_state <= w_state_nxt;
      r_err <= r_err | w_err_set;
      if (w_mrs) begin
        r_cl <= cl_ok(ADR[MRS_CL_LSB +: 3]) ? ADR[MRS_CL_LSB +: 3] : CL_DEFAULT;
        r_bl <= ADR[MRS_BL_LSB +: 3];
      end
    end
  // burst progress: a new access restarts it, terminating commands stop it
  always_ff @(posedge CLK)
    if (RST) begin
      r_bst_act <= 1'b0;
      r_bst_wr <= 1'b0;
      r_bst_full <= 1'b0;
      r_bst_bank <= '0;
      r_bst_row <= '0;
      r_bst_col <= '0;
      r_bst_left <= '0;
      r_bst_mask <= '0;
    end else begin
      if (w_acc) begin
        r_bst_act <= r_bl == BL_PAGE || |w_bmask;
        r_bst_full <= r_bl == BL_PAGE;
        r_bst_left <= w_bmask;
        r_bst_mask <= w_bmask;
        r_bst_wr <= w_bwr;
        r_bst_bank <= w_bbank;
        r_bst_row <= w_brow;
      end else if (w_kill) r_bst_act <= 1'b0;
      else if (r_bst_act) begin
        r_bst_left <= r_bst_left - 1'b1;
        r_bst_act <= r_bst_full || |r_bst_left[COL_BITS-1:1];
      end
      if (w_beat) r_bst_col <= w_bcol_nxt;
    end
  // storage keeps its contents across reset; a same-cycle fetch sees the old word
  always_ff @(posedge CLK)
    if (w_beat && w_bwr) r_mem[w_idx] <= DQ_IN;
  // read-valid pipeline, flushed by reset
  always_ff @(posedge CLK)
    if (RST) r_pv <= '0;
    else r_pv <= {r_pv[1:0], w_beat && !w_bwr};
  // read-data pipeline, qualified by the valid bits
  always_ff @(posedge CLK) begin
    r_pd[0] <= r_mem[w_idx];
    r_pd[1] <= r_pd[0];
    r_pd[2] <= r_pd[1];
  end
  assign READY = w_run;
  assign CAS_LAT = r_cl;
  assign ERR = r_err;
  assign DQ_OE = r_cl == 3'd2 ? r_pv[1] : r_pv[2];
  assign DQ_OUT = DQ_OE ? (r_cl == 3'd2 ? r_pd[1] : r_pd[2]) : '0;
endmodule
